hash_sequencer: RTL and testbench

Controller that sequences the shared SHA-256 core over the packet decoder's block storage for one mining job. It walks the three hash passes per nonce (chunk 1, chunk 2, digest re-hash) by driving hash_select and sha_start, and compares the final digest against difficulty. On a miss it pulses increment to the nonce; on a hit or exhaustion it reports hash_done. It sits between the packet decoder controller (begin_hash/quit_hash) and the SHA core, and drives the decoder's hash_select, increment and hash_done inputs.

---
 rtl/hash_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_hash_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hash_sequencer
//
// Sequences the shared SHA-256 core for one mining job. For every nonce it runs
// three passes over the decoder's block storage (chunk 1, chunk 2 and the
// re-hash of the intermediate digest). It then compares the final digest with
// the difficulty target. On a miss it pulses increment and tries the next
// nonce. On a hit, or once MAX_ATTEMPTS nonces have been tried, it pulses
// hash_done.
//
// Parameters
//   MAX_ATTEMPTS  nonces tried before giving up (>= 1)
//   SHA_TIMEOUT   WAIT cycles tolerated without sha_done before sha_error
//
// Ports
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   begin_hash   pulse: start a new job (honoured only in IDLE)
//   quit_hash    pulse: abort the current job / clear nonce_found
//   difficulty   256-bit target; a digest must be strictly below it
//   sha_done     SHA core pass complete, sha_digest valid
//   sha_digest   SHA core result (bit 255 = MSB)
//   hash_select  block storage select: 0 chunk 1, 1 chunk 2, 2 digest re-hash
//   sha_start    one-cycle pulse launching a SHA pass
//   sha_init     with sha_start: 1 = start from IV, 0 = continue state
//   increment    one-cycle pulse advancing the stored nonce
//   hash_done    one-cycle pulse: job finished (found or exhausted)
//   nonce_found  level: the last job found a valid nonce
//   sha_error    one-cycle pulse: SHA core timed out, job abandoned
//   busy         high whenever the sequencer is not IDLE
//   attempts     nonces tried in the current / last job
// -----------------------------------------------------------------------------
module hash_sequencer #(
   parameter logic [31:0] MAX_ATTEMPTS = 32'hFFFF_FFFF,
   parameter int unsigned SHA_TIMEOUT  = 128
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         begin_hash,
   input  logic         quit_hash,
   input  logic [255:0] difficulty,
   input  logic         sha_done,
   input  logic [255:0] sha_digest,
   output logic [1:0]   hash_select,
   output logic         sha_start,
   output logic         sha_init,
   output logic         increment,
   output logic         hash_done,
   output logic         nonce_found,
   output logic         sha_error,
   output logic         busy,
   output logic [31:0]  attempts
);

   // Wide enough to hold the value SHA_TIMEOUT itself.
   localparam int TMO_W = $clog2(SHA_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      C1_START = 4'd1,
      C1_WAIT  = 4'd2,
      C2_START = 4'd3,
      C2_WAIT  = 4'd4,
      D_START  = 4'd5,
      D_WAIT   = 4'd6,
      COMPARE  = 4'd7,
      INCR     = 4'd8,
      SETTLE   = 4'd9,
      DONE     = 4'd10
   } state_t;

   state_t            state_reg, state_next;
   logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
   logic [255:0]      digest_reg, digest_next;
   logic [31:0]       attempts_reg, attempts_next;
   logic              found_reg, found_next;

   logic              timed_out;
   logic              digest_hit;
   logic              last_attempt;
   logic [31:0]       attempts_inc;

   // The timeout counter is only meaningful inside a WAIT state; it is zero
   // in every START state, so each WAIT begins counting from zero.
   assign timed_out    = (tmo_cnt_reg == TMO_W'(SHA_TIMEOUT));
   assign digest_hit   = (digest_reg < difficulty);
   assign last_attempt = ((attempts_reg + 32'd1) == MAX_ATTEMPTS);
   // Saturating so the counter can never wrap back to zero.
   assign attempts_inc = (attempts_reg == MAX_ATTEMPTS) ? attempts_reg
                                                        : attempts_reg + 32'd1;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg    <= IDLE;
         tmo_cnt_reg  <= '0;
         digest_reg   <= '0;
         attempts_reg <= '0;
         found_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         digest_reg   <= digest_next;
         attempts_reg <= attempts_next;
         found_reg    <= found_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      tmo_cnt_next  = '0;
      digest_next   = digest_reg;
      attempts_next = attempts_reg;
      found_next    = found_reg;
      hash_select   = 2'd0;
      sha_start     = 1'b0;
      sha_init      = 1'b0;
      increment     = 1'b0;
      hash_done     = 1'b0;
      sha_error     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (quit_hash) begin
               // quit wins over a simultaneous begin: stay idle
               found_next = 1'b0;
            end else if (begin_hash) begin
               attempts_next = '0;
               found_next    = 1'b0;
               state_next    = C1_START;
            end
         end

         C1_START: begin
            hash_select = 2'd0;
            sha_start   = 1'b1;
            sha_init    = 1'b1;
            state_next  = C1_WAIT;
         end

         C1_WAIT: begin
            hash_select = 2'd0;
            if (timed_out) begin
               sha_error  = 1'b1;
               state_next = IDLE;
            end else if (sha_done) begin
               state_next = C2_START;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end

         C2_START: begin
            // chunk 2 continues from the chunk-1 midstate
            hash_select = 2'd1;
            sha_start   = 1'b1;
            sha_init    = 1'b0;
            state_next  = C2_WAIT;
         end

         C2_WAIT: begin
            hash_select = 2'd1;
            if (timed_out) begin
               sha_error  = 1'b1;
               state_next = IDLE;
            end else if (sha_done) begin
               state_next = D_START;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end

         D_START: begin
            // second SHA-256 over the first digest starts from a fresh IV
            hash_select = 2'd2;
            sha_start   = 1'b1;
            sha_init    = 1'b1;
            state_next  = D_WAIT;
         end

         D_WAIT: begin
            hash_select = 2'd2;
            if (timed_out) begin
               sha_error  = 1'b1;
               state_next = IDLE;
            end else if (sha_done) begin
               digest_next = sha_digest;
               state_next  = COMPARE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end

         COMPARE: begin
            attempts_next = attempts_inc;
            if (digest_hit) begin
               found_next = 1'b1;
               state_next = DONE;
            end else if (last_attempt) begin
               state_next = DONE;
            end else begin
               state_next = INCR;
            end
         end

         INCR: begin
            increment  = 1'b1;
            state_next = SETTLE;
         end

         SETTLE: begin
            // give block storage a cycle to present the new nonce
            state_next = C1_START;
         end

         DONE: begin
            hash_done  = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort overrides everything above: no pulses leave the block this
      // cycle, the job result is discarded, and attempts keeps its value.
      if (quit_hash && (state_reg != IDLE)) begin
         state_next    = IDLE;
         tmo_cnt_next  = '0;
         digest_next   = digest_reg;
         attempts_next = attempts_reg;
         found_next    = 1'b0;
         sha_start     = 1'b0;
         sha_init      = 1'b0;
         increment     = 1'b0;
         hash_done     = 1'b0;
         sha_error     = 1'b0;
      end
   end

   assign busy        = (state_reg != IDLE);
   assign nonce_found = found_reg;
   assign attempts    = attempts_reg;

endmodule

// File: tb/tb_hash_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hash_sequencer
//
// Bench for hash_sequencer with MAX_ATTEMPTS=3 and SHA_TIMEOUT=16. A model SHA
// core answers each sha_start after a programmable latency. On the re-hash
// pass it returns the next digest from a per-job queue. Job outcomes are
// predicted from the digest list and the difficulty alone.
// -----------------------------------------------------------------------------
module tb_hash_sequencer;

   localparam logic [31:0] MAX_ATT = 32'd3;
   localparam int          TMO     = 16;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         begin_hash;
   logic         quit_hash;
   logic [255:0] difficulty;
   logic         sha_done;
   logic [255:0] sha_digest;
   logic [1:0]   hash_select;
   logic         sha_start;
   logic         sha_init;
   logic         increment;
   logic         hash_done;
   logic         nonce_found;
   logic         sha_error;
   logic         busy;
   logic [31:0]  attempts;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hash_sequencer #(
      .MAX_ATTEMPTS (MAX_ATT),
      .SHA_TIMEOUT  (TMO)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .begin_hash  (begin_hash),
      .quit_hash   (quit_hash),
      .difficulty  (difficulty),
      .sha_done    (sha_done),
      .sha_digest  (sha_digest),
      .hash_select (hash_select),
      .sha_start   (sha_start),
      .sha_init    (sha_init),
      .increment   (increment),
      .hash_done   (hash_done),
      .nonce_found (nonce_found),
      .sha_error   (sha_error),
      .busy        (busy),
      .attempts    (attempts)
   );

   // ---------------------------------------------------------------------
   // Model SHA core and event log (all activity on the falling edge)
   // ---------------------------------------------------------------------
   bit           core_enable  = 1'b1;
   int           core_latency = 10;
   int           countdown;
   logic [1:0]   pend_sel;
   logic [255:0] job_digests[$];
   int           cyc;
   int           sel_log[$];
   int           init_log[$];
   int           start_cyc[$];
   int           inc_cyc[$];
   int           n_done;
   int           n_err;
   int           err_cyc;

   initial begin
      sha_done   = 1'b0;
      sha_digest = '0;
      countdown  = 0;
      cyc        = 0;
      forever begin
         @(negedge clk);
         cyc++;
         sha_done = 1'b0;
         if (!n_rst) begin
            countdown = 0;
         end else begin
            if (countdown > 0) begin
               countdown--;
               if (countdown == 0) begin
                  sha_done = 1'b1;
                  if (pend_sel == 2'd2) begin
                     if (job_digests.size() > 0) sha_digest = job_digests.pop_front();
                     else                        sha_digest = '1;
                  end else begin
                     for (int w = 0; w < 8; w++) sha_digest[w*32 +: 32] = $urandom;
                  end
               end
            end
            if (sha_start) begin
               sel_log.push_back(int'(hash_select));
               init_log.push_back(int'(sha_init));
               start_cyc.push_back(cyc);
               if (core_enable) begin
                  countdown = core_latency;
                  pend_sel  = hash_select;
               end
            end
            if (increment) inc_cyc.push_back(cyc);
            if (hash_done) n_done++;
            if (sha_error) begin
               n_err++;
               err_cyc = cyc;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers (no checking)
   // ---------------------------------------------------------------------
   task automatic clear_logs();
      sel_log.delete();
      init_log.delete();
      start_cyc.delete();
      inc_cyc.delete();
      n_done  = 0;
      n_err   = 0;
      err_cyc = -1;
   endtask

   task automatic pulse_begin();
      @(posedge clk); #1 begin_hash = 1'b1;
      @(posedge clk); #1 begin_hash = 1'b0;
   endtask

   function automatic logic [255:0] rand_big();
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
      r[255:248] = 8'($urandom_range(16, 240));
      return r;
   endfunction

   // Launch one job with the digests already queued; wait for its end.
   task automatic run_job(input int lat, input bit mid_begin, output bit tmo);
      clear_logs();
      core_enable  = 1'b1;
      core_latency = lat;
      pulse_begin();
      if (mid_begin) begin
         repeat (4) @(posedge clk);
         #1 begin_hash = 1'b1;
         @(posedge clk); #1 begin_hash = 1'b0;
      end
      tmo = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (n_done != 0 || n_err != 0) begin
            tmo = 1'b0;
            break;
         end
         @(posedge clk);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset();
      n_rst      = 1'b0;
      begin_hash = 1'b0;
      quit_hash  = 1'b0;
      difficulty = '0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (sha_start !== 1'b0) begin failures++; $display("FAIL reset_sha_start got=%0b exp=0", sha_start); end
      checks++; if (hash_select !== 2'd0) begin failures++; $display("FAIL reset_hash_select got=%0d exp=0", hash_select); end
      checks++; if (attempts !== 32'd0) begin failures++; $display("FAIL reset_attempts got=%0d exp=0", attempts); end
      checks++; if (nonce_found !== 1'b0) begin failures++; $display("FAIL reset_nonce_found got=%0b exp=0", nonce_found); end
      checks++; if ({increment, hash_done, sha_error, sha_init} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {increment, hash_done, sha_error, sha_init}); end
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      $display("reset: busy=%0b attempts=%0d", busy, attempts);
   endtask

   // Directed scenarios 0..3, then randomized jobs, all checked against a
   // model derived only from the digest list and the difficulty.
   task automatic test_jobs();
      logic [255:0] diff;
      logic [255:0] digs[$];
      int           lat, n, exp_att, nstart;
      bit           exp_found, mid, tmo;
      for (int s = 0; s < 16; s++) begin
         digs.delete();
         mid = 1'b0;
         lat = 10;
         diff = 256'd1;
         diff = diff << 252;
         case (s)
            0: digs.push_back(256'd1);                                  // hit first
            1: begin digs.push_back('1); digs.push_back('0); end        // miss then hit
            2: begin diff = rand_big(); digs.push_back(diff); digs.push_back('0); end  // equal is a miss
            3: begin digs.push_back('1); digs.push_back('1); digs.push_back('1); end   // exhaustion
            default: begin
               diff = rand_big();
               n = $urandom_range(0, 4);
               for (int i = 0; i < n; i++) begin
                  if ($urandom_range(0, 2) == 0) digs.push_back(diff - 256'($urandom_range(1, 1000)));
                  else                           digs.push_back(diff + 256'($urandom_range(0, 1000)));
               end
               lat = $urandom_range(1, 12);
               mid = 1'($urandom_range(0, 1));
            end
         endcase

         exp_att   = int'(MAX_ATT);
         exp_found = 1'b0;
         for (int i = 0; i < digs.size() && i < int'(MAX_ATT); i++) begin
            if (!exp_found && digs[i] < diff) begin
               exp_att   = i + 1;
               exp_found = 1'b1;
            end
         end

         difficulty  = diff;
         job_digests = digs;
         run_job(lat, mid, tmo);
         $display("job %0d: lat=%0d digests=%0d attempts=%0d found=%0b starts=%0d incs=%0d",
                  s, lat, digs.size(), attempts, nonce_found, sel_log.size(), inc_cyc.size());

         checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL job%0d_no_end got=timeout exp=hash_done", s); end
         checks++; if (n_done != 1) begin failures++; $display("FAIL job%0d_hash_done_count got=%0d exp=1", s, n_done); end
         checks++; if (n_err != 0) begin failures++; $display("FAIL job%0d_sha_error_count got=%0d exp=0", s, n_err); end
         checks++; if (attempts !== 32'(exp_att)) begin failures++; $display("FAIL job%0d_attempts got=%0d exp=%0d", s, attempts, exp_att); end
         checks++; if (nonce_found !== exp_found) begin failures++; $display("FAIL job%0d_nonce_found got=%0b exp=%0b", s, nonce_found, exp_found); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL job%0d_busy_after got=%0b exp=0", s, busy); end
         checks++; if (sel_log.size() != 3 * exp_att) begin failures++; $display("FAIL job%0d_start_count got=%0d exp=%0d", s, sel_log.size(), 3 * exp_att); end
         checks++; if (inc_cyc.size() != exp_att - 1) begin failures++; $display("FAIL job%0d_increment_count got=%0d exp=%0d", s, inc_cyc.size(), exp_att - 1); end

         nstart = sel_log.size();
         for (int p = 0; p < nstart; p++) begin
            checks++;
            if (sel_log[p] != p % 3 || init_log[p] != ((p % 3 == 1) ? 0 : 1)) begin
               failures++;
               $display("FAIL job%0d_pass%0d_select_init got=%0d/%0d exp=%0d/%0d",
                        s, p, sel_log[p], init_log[p], p % 3, (p % 3 == 1) ? 0 : 1);
            end
         end
         // next nonce's chunk-1 start follows the increment after one SETTLE cycle
         for (int k = 0; k < inc_cyc.size(); k++) begin
            if (3 * (k + 1) < nstart) begin
               checks++;
               if (start_cyc[3 * (k + 1)] != inc_cyc[k] + 2) begin
                  failures++;
                  $display("FAIL job%0d_settle_gap%0d got=%0d exp=%0d", s, k, start_cyc[3 * (k + 1)] - inc_cyc[k], 2);
               end
            end
         end
      end
   endtask

   task automatic test_quit_idle();
      bit tmo;
      difficulty = 256'd1 << 252;
      job_digests.delete();
      job_digests.push_back('0);
      run_job(5, 1'b0, tmo);
      checks++; if (nonce_found !== 1'b1) begin failures++; $display("FAIL quit_idle_setup_found got=%0b exp=1", nonce_found); end
      @(posedge clk); #1 quit_hash = 1'b1;
      @(posedge clk); #1 quit_hash = 1'b0;
      checks++; if (nonce_found !== 1'b0) begin failures++; $display("FAIL quit_idle_found got=%0b exp=0", nonce_found); end
      checks++; if (attempts !== 32'd1) begin failures++; $display("FAIL quit_idle_attempts got=%0d exp=1", attempts); end
      clear_logs();
      begin_hash = 1'b1;
      quit_hash  = 1'b1;
      @(posedge clk); #1;
      begin_hash = 1'b0;
      quit_hash  = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL begin_quit_busy got=%0b exp=0", busy); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (sel_log.size() != 0) begin failures++; $display("FAIL begin_quit_starts got=%0d exp=0", sel_log.size()); end
      checks++; if (attempts !== 32'd1) begin failures++; $display("FAIL begin_quit_attempts got=%0d exp=1", attempts); end
      $display("quit_idle: found=%0b attempts=%0d", nonce_found, attempts);
   endtask

   task automatic test_quit_start();
      clear_logs();
      core_enable = 1'b1;
      @(posedge clk); #1 begin_hash = 1'b1;
      @(posedge clk); #1 begin_hash = 1'b0;
      quit_hash = 1'b1;                       // lands in C1_START
      @(posedge clk); #1 quit_hash = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL quit_start_busy got=%0b exp=0", busy); end
      repeat (15) @(posedge clk);
      #1;
      checks++; if (sel_log.size() != 0) begin failures++; $display("FAIL quit_start_sha_start got=%0d exp=0", sel_log.size()); end
      checks++; if (n_done != 0) begin failures++; $display("FAIL quit_start_hash_done got=%0d exp=0", n_done); end
      $display("quit_start: starts=%0d busy=%0b", sel_log.size(), busy);
   endtask

   task automatic test_abort();
      bit seen;
      clear_logs();
      difficulty = 256'd1 << 252;
      job_digests.delete();
      job_digests.push_back('0);
      core_enable  = 1'b1;
      core_latency = 10;
      pulse_begin();
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         if (start_cyc.size() >= 2) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL abort_c2_start got=absent exp=present"); end
      // chunk-2 start was one cycle ago; sha_done arrives in WAIT cycle 10
      repeat (9) @(posedge clk);
      #1 quit_hash = 1'b1;
      @(posedge clk); #1 quit_hash = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
      repeat (20) @(posedge clk);
      #1;
      checks++; if (sel_log.size() != 2) begin failures++; $display("FAIL abort_no_d_start got=%0d exp=2", sel_log.size()); end
      checks++; if (n_done != 0) begin failures++; $display("FAIL abort_hash_done got=%0d exp=0", n_done); end
      checks++; if (nonce_found !== 1'b0) begin failures++; $display("FAIL abort_nonce_found got=%0b exp=0", nonce_found); end
      checks++; if (attempts !== 32'd0) begin failures++; $display("FAIL abort_attempts got=%0d exp=0", attempts); end
      $display("abort: starts=%0d busy=%0b found=%0b", sel_log.size(), busy, nonce_found);
      job_digests.delete();
   endtask

   task automatic test_timeout();
      clear_logs();
      core_enable = 1'b0;
      pulse_begin();
      for (int i = 0; i < 100 && n_err == 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (n_err != 1) begin failures++; $display("FAIL timeout_sha_error_count got=%0d exp=1", n_err); end
      if (start_cyc.size() > 0) begin
         // WAIT is entered one cycle after the start; error 16 cycles later
         checks++; if (err_cyc != start_cyc[0] + 1 + TMO) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", err_cyc - start_cyc[0], 1 + TMO); end
      end
      checks++; if (sel_log.size() != 1) begin failures++; $display("FAIL timeout_starts got=%0d exp=1", sel_log.size()); end
      checks++; if (n_done != 0) begin failures++; $display("FAIL timeout_hash_done got=%0d exp=0", n_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
      $display("timeout: errors=%0d busy=%0b", n_err, busy);
      core_enable = 1'b1;
   endtask

   task automatic test_reset_midjob();
      bit seen, tmo;
      clear_logs();
      difficulty = 256'd1 << 252;
      job_digests.delete();
      job_digests.push_back('1);
      job_digests.push_back('0);
      core_enable  = 1'b1;
      core_latency = 10;
      pulse_begin();
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk); #1;
         if (start_cyc.size() >= 6) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL rstmid_second_d_start got=absent exp=present"); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1 || hash_select !== 2'd2) begin failures++; $display("FAIL rstmid_pre_state got=busy%0b/sel%0d exp=busy1/sel2", busy, hash_select); end
      checks++; if (attempts !== 32'd1) begin failures++; $display("FAIL rstmid_pre_attempts got=%0d exp=1", attempts); end
      n_rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
      checks++; if (hash_select !== 2'd0) begin failures++; $display("FAIL rstmid_hash_select got=%0d exp=0", hash_select); end
      checks++; if (attempts !== 32'd0) begin failures++; $display("FAIL rstmid_attempts got=%0d exp=0", attempts); end
      checks++; if ({sha_start, increment, hash_done, sha_error, nonce_found} !== 5'b0) begin failures++; $display("FAIL rstmid_outputs got=%b exp=00000", {sha_start, increment, hash_done, sha_error, nonce_found}); end
      @(posedge clk); #1 n_rst = 1'b1;
      job_digests.delete();
      job_digests.push_back('0);
      run_job(10, 1'b0, tmo);
      checks++; if (tmo !== 1'b0 || n_done != 1) begin failures++; $display("FAIL rstmid_new_job_done got=%0d exp=1", n_done); end
      checks++; if (attempts !== 32'd1) begin failures++; $display("FAIL rstmid_new_job_attempts got=%0d exp=1", attempts); end
      checks++; if (nonce_found !== 1'b1) begin failures++; $display("FAIL rstmid_new_job_found got=%0b exp=1", nonce_found); end
      checks++; if (sel_log.size() != 3) begin failures++; $display("FAIL rstmid_new_job_starts got=%0d exp=3", sel_log.size()); end
      $display("reset_midjob: attempts=%0d found=%0b", attempts, nonce_found);
   endtask

   initial begin
      test_reset();
      test_jobs();
      test_quit_idle();
      test_quit_start();
      test_abort();
      test_timeout();
      test_reset_midjob();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
